// File: rtl/imm_gen_pkg.sv
// Shared definitions for the pipelined immediate generator: pick encodings,
// buffered entry layout and error-counter limits.
package imm_gen_pkg;

   localparam int unsigned PICK_W      = 3;
   localparam int unsigned IMM_MAX_W   = 64;
   localparam int unsigned TAG_MAX_W   = 16;
   localparam int unsigned ERR_CNT_W   = 8;
   localparam int unsigned ERR_CNT_MAX = 255;

   localparam logic [PICK_W-1:0] IMM_I = 3'b000;
   localparam logic [PICK_W-1:0] IMM_S = 3'b001;
   localparam logic [PICK_W-1:0] IMM_U = 3'b010;
   localparam logic [PICK_W-1:0] IMM_B = 3'b011;
   localparam logic [PICK_W-1:0] IMM_J = 3'b100;
   localparam logic [PICK_W-1:0] IMM_Z = 3'b101;

   // Sized for the widest legal configuration; instances use the low bits.
   typedef struct packed {
      logic [IMM_MAX_W-1:0] imm;
      logic [TAG_MAX_W-1:0] tag;
      logic                 err;
   } imm_entry_t;

endpackage

// File: rtl/imm_extract.sv
// Combinational RISC-V immediate extraction and sign extension to XLEN.
// Pick 101 (CSR zimm) is legal only when IMM_GEN_ZIMM_EN is defined.
module imm_extract
   import imm_gen_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [31:0]       instruction,
   input  logic [PICK_W-1:0] pick,
   output logic [XLEN-1:0]   imm_c,
   output logic              err_c
);

   logic signed [31:0] imm32;
   logic               use_zimm;
   logic               unused_opcode;

   // Opcode bits never contribute to any immediate.
   assign unused_opcode = ^instruction[6:0];

   always_comb begin
      imm32    = '0;
      use_zimm = 1'b0;
      err_c    = 1'b0;
      case (pick)
         IMM_I: imm32 = {{20{instruction[31]}}, instruction[31:20]};
         IMM_S: imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
         IMM_U: imm32 = {instruction[31:12], 12'b0};
         IMM_B: imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                         instruction[30:25], instruction[11:8], 1'b0};
         IMM_J: imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                         instruction[20], instruction[30:21], 1'b0};
`ifdef IMM_GEN_ZIMM_EN
         IMM_Z: use_zimm = 1'b1;
`endif
         default: err_c = 1'b1;
      endcase
   end

   // Signed 32-bit result widens with sign; zimm widens with zeros.
   assign imm_c = use_zimm ? XLEN'(instruction[19:15]) : XLEN'(imm32);

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with one-cycle latency behind a two-entry skid buffer,
// illegal-pick flag and saturating error count. Optional: IMM_GEN_ZIMM_EN.
module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 5
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 IN_VALID,
   output logic                 IN_READY,
   input  logic [31:0]          INSTRUCTION,
   input  logic [PICK_W-1:0]    IMM_PICK,
   input  logic [TAG_W-1:0]     IN_TAG,
   output logic                 OUT_VALID,
   input  logic                 OUT_READY,
   output logic [XLEN-1:0]      IMMEDIATE,
   output logic [TAG_W-1:0]     OUT_TAG,
   output logic                 OUT_PICK_ERR,
   output logic [ERR_CNT_W-1:0] ERR_COUNT
);

   logic [XLEN-1:0]      ext_imm;
   logic                 ext_err;
   imm_entry_t           in_entry;
   imm_entry_t           out_q, out_d;
   imm_entry_t           skid_q, skid_d;
   logic                 out_valid_q, out_valid_d;
   logic                 skid_valid_q, skid_valid_d;
   logic                 in_ready_q;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic                 in_fire;
   logic                 out_free;
   logic                 unused_hi;

   imm_extract #(.XLEN(XLEN)) u_extract (
      .instruction (INSTRUCTION),
      .pick        (IMM_PICK),
      .imm_c       (ext_imm),
      .err_c       (ext_err)
   );

   always_comb begin
      in_entry     = '0;
      in_entry.imm = IMM_MAX_W'(ext_imm);
      in_entry.tag = TAG_MAX_W'(IN_TAG);
      in_entry.err = ext_err;
   end

   assign in_fire  = IN_VALID & in_ready_q;
   assign out_free = ~out_valid_q | OUT_READY;

   // Skid has priority for the output slot; it can only be full when in_ready is low.
   always_comb begin
      out_d        = out_q;
      skid_d       = skid_q;
      out_valid_d  = out_valid_q;
      skid_valid_d = skid_valid_q;
      err_cnt_d    = err_cnt_q;
      if (out_free) begin
         if (skid_valid_q) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else if (in_fire) begin
            out_d       = in_entry;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (in_fire) begin
         skid_d       = in_entry;
         skid_valid_d = 1'b1;
      end
      if (in_fire && in_entry.err && (err_cnt_q != ERR_CNT_W'(ERR_CNT_MAX))) begin
         err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         out_q        <= '0;
         skid_q       <= '0;
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
         err_cnt_q    <= '0;
      end else begin
         out_q        <= out_d;
         skid_q       <= skid_d;
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= ~skid_valid_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   // Upper entry bits beyond XLEN/TAG_W are padding.
   assign unused_hi = ^{out_q.imm, out_q.tag};

   assign IN_READY     = in_ready_q;
   assign OUT_VALID    = out_valid_q;
   assign IMMEDIATE    = out_q.imm[XLEN-1:0];
   assign OUT_TAG      = out_q.tag[TAG_W-1:0];
   assign OUT_PICK_ERR = out_q.err;
   assign ERR_COUNT    = err_cnt_q;

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. It accepts one 32-bit RISC-V instruction per cycle with a format select, extracts and sign-extends the immediate to `XLEN` bits, and presents it one cycle later behind a valid/ready handshake. A two-entry skid buffer gives full throughput under back-pressure. It also adds an illegal-format flag and a saturating error counter, which the combinational picker lacked.

## Interface
Parameters:
- `XLEN`, 32: immediate output width. Legal values are 32 and 64.
- `TAG_W`, 5: width of the sideband tag (e.g. rd index) carried alongside the immediate.

Ports:
- `CLK` in 1: single clock. All logic is on the rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `IN_VALID` in 1: upstream offers an instruction.
- `IN_READY` out 1: block can accept. Registered.
- `INSTRUCTION` in 32: raw instruction word.
- `IMM_PICK` in 3: format select.
- `IN_TAG` in `TAG_W`: sideband, passed through unchanged.
- `OUT_VALID` out 1: immediate available.
- `OUT_READY` in 1: downstream accepts.
- `IMMEDIATE` out `XLEN`: extracted immediate.
- `OUT_TAG` out `TAG_W`: tag matching `IMMEDIATE`.
- `OUT_PICK_ERR` out 1: the output entry had an illegal `IMM_PICK`.
- `ERR_COUNT` out 8: saturating count of accepted illegal picks.

## Operation
- A transfer happens on the input when `IN_VALID & IN_READY`, and on the output when `OUT_VALID & OUT_READY`.
- `IMM_PICK` encodings. "sx" means sign-extended from `INSTRUCTION[31]` to `XLEN`.
  - 000 I: sx `INSTRUCTION[31:20]`.
  - 001 S: sx `{INSTRUCTION[31:25], INSTRUCTION[11:7]}`.
  - 010 U: sx `{INSTRUCTION[31:12], 12'b0}`.
  - 011 B: sx `{INSTRUCTION[31], INSTRUCTION[7], INSTRUCTION[30:25], INSTRUCTION[11:8], 1'b0}`.
  - 100 J: sx `{INSTRUCTION[31], INSTRUCTION[19:12], INSTRUCTION[20], INSTRUCTION[30:21], 1'b0}`.
  - 101: Z-type. See Configuration.
  - 110, 111: illegal. `IMMEDIATE` is 0 and `OUT_PICK_ERR` is 1.
- Storage is an output register plus one skid register. Each holds `{immediate, tag, err}` and a valid bit.
- `IN_READY` is 1 exactly when the skid register is empty.
- When the output register is empty or is being drained this cycle, it loads from the skid register if that is full, otherwise from an accepted input.
- An input accepted while the output register holds and is stalled goes to the skid register.
- Entries leave in arrival order. None are dropped or duplicated.
- `ERR_COUNT` increments by 1 on each accepted input with an illegal pick. It saturates at 255 and clears only on reset.

## Timing
- Latency is 1 cycle: an input accepted at edge N is visible on the output after edge N.
- Throughput is 1 per cycle while `OUT_READY` stays 1.
- Reset values: `OUT_VALID` 0, `IN_READY` 1, `IMMEDIATE` 0, `OUT_TAG` 0, `OUT_PICK_ERR` 0, `ERR_COUNT` 0. Both valid bits are cleared.
- Full condition: with the output and skid registers both holding, `IN_READY` is 0 on the next cycle. `IN_VALID` is ignored until the skid drains.
- Simultaneous input and output transfers with the skid register empty: the output register takes the new entry directly and the skid register stays empty.
- Skid full and output drained in the same cycle: skid moves to output and `IN_READY` returns to 1 the following cycle.
- Reset mid-operation discards all in-flight entries. No output transfer occurs in the reset cycle.
- Payload is stable while `OUT_VALID & ~OUT_READY`.

## Configuration
- Macro `IMM_GEN_ZIMM_EN`.
- Defined: `IMM_PICK` 101 produces the CSR zimm, `{(XLEN-5)'b0, INSTRUCTION[19:15]}` (zero-extended), and it is legal.
- Undefined: 101 is illegal. It yields `IMMEDIATE` 0, `OUT_PICK_ERR` 1, and increments `ERR_COUNT`.

## Structure
- Shared package `imm_gen_pkg` holds:
  - the `IMM_PICK` encoding constants (`IMM_I`, `IMM_S`, `IMM_U`, `IMM_B`, `IMM_J`, `IMM_Z`);
  - the entry struct typedef `{imm, tag, err}`;
  - `ERR_CNT_MAX` = 255.
- Sub-module `imm_extract`: purely combinational. Takes instruction and pick and produces `{imm, err}`. It is instantiated once ahead of the skid/output registers.

## Test plan
- Reset, then I-type 0xFFF00000 and I-type 0x000FFFFF with `OUT_READY`=1. Outputs are 0xFFFFFFFF then 0x00000000, each 1 cycle after acceptance.
- S 0xFE000F80 gives 0xFFFFFFFF. B 0xFE000F80 gives 0xFFFFFFFE. U 0xFFFFF000 gives 0xFFFFF000. J 0x87654321 gives 0xFFF54076. With `XLEN`=64, J gives 0xFFFFFFFFFFF54076.
- Back-pressure: `OUT_READY`=0, push tags 1 and 2. `IN_READY` drops after the second push. Release `OUT_READY`: tags emerge as 1 then 2 on consecutive cycles with payloads intact.
- Illegal picks 110 and 111: `IMMEDIATE` 0 and `OUT_PICK_ERR` 1. Push 300 illegal picks: `ERR_COUNT` holds at 255.
- Pick 101 with instruction 0x000F8073:
  - with `IMM_GEN_ZIMM_EN` defined: `IMMEDIATE` 0x1F, `OUT_PICK_ERR` 0;
  - without it: `IMMEDIATE` 0, `OUT_PICK_ERR` 1.
- Assert `RESET` while both registers are full. The next cycle shows `OUT_VALID` 0, `IN_READY` 1, `ERR_COUNT` 0, and no stale entry ever emerges.
